// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the user-mode CSR file and trap responder:
// CSR addresses, trap cause codes, status/enable/pending bit positions and FSM states.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_USTATUS  = 12'h000;
  localparam logic [11:0] CSR_UIE      = 12'h004;
  localparam logic [11:0] CSR_UTVEC    = 12'h005;
  localparam logic [11:0] CSR_USCRATCH = 12'h040;
  localparam logic [11:0] CSR_UEPC     = 12'h041;
  localparam logic [11:0] CSR_UCAUSE   = 12'h042;
  localparam logic [11:0] CSR_UTVAL    = 12'h043;
  localparam logic [11:0] CSR_UIP      = 12'h044;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_ECALL    = 32'd8;
  localparam logic [31:0] CAUSE_UEXT_IRQ = 32'h8000_0008;

  localparam int USTATUS_UIE  = 0;
  localparam int USTATUS_UPIE = 4;
  localparam int UIE_UEIE     = 8;
  localparam int UIP_UEIP     = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_BREAK   = 2'd2,
    ST_FAULT   = 2'd3
  } trap_state_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Decoder/PC-mux side bundle of the trap unit: strobes from the core in, trap
// vector, uepc, CSR read data and halt out.
interface csr_trap_unit_if;
  logic        iEnable;
  logic [31:0] iPC;
  logic [31:0] iInstr;
  logic        iEcall;
  logic        iEbreak;
  logic        iInvInstr;
  logic        iUret;
  logic        iCSRWrite;
  logic [11:0] iCSRAddr;
  logic [31:0] iCSRWData;
  logic        iExtIrq;
  logic        iResume;
  logic [31:0] oCSRRData;
  logic        oTrapTaken;
  logic [31:0] oTrapPC;
  logic [31:0] oEPC;
  logic        oHalt;

  modport master (
    output iEnable, iPC, iInstr, iEcall, iEbreak, iInvInstr, iUret,
           iCSRWrite, iCSRAddr, iCSRWData, iExtIrq, iResume,
    input  oCSRRData, oTrapTaken, oTrapPC, oEPC, oHalt
  );

  modport slave (
    input  iEnable, iPC, iInstr, iEcall, iEbreak, iInvInstr, iUret,
           iCSRWrite, iCSRAddr, iCSRWData, iExtIrq, iResume,
    output oCSRRData, oTrapTaken, oTrapPC, oEPC, oHalt
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running event counter with enable and synchronous active-low clear;
// wraps from all-ones to zero, read as two 32-bit halves.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic        en_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign lo_o = cnt_q[31:0];
  assign hi_o = cnt_q[63:32];

endmodule

// File: rtl/csr_trap_unit.sv
// User-mode CSR file and trap responder for the single-cycle RV32 core: takes
// exceptions/interrupts, handles uret/ebreak, and halts the core on BREAK or FAULT.
module csr_trap_unit
  import riscv_csr_pkg::*;
#(
  parameter logic [31:0] TVEC_RESET   = 32'h0040_0000,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic          iCLK,
  input  logic          iRST,
  csr_trap_unit_if.slave bus
);

  trap_state_e state_q, state_d, ret_q, ret_d;
  logic        st_uie_q, st_uie_d, st_upie_q, st_upie_d;
  logic        ueie_q, ueie_d, ueip_q, ueip_d;
  logic [31:0] utvec_q, utvec_d, uscratch_q, uscratch_d, uepc_q, uepc_d;
  logic [31:0] ucause_q, ucause_d, utval_q, utval_d;

  logic        halt, active, sync_exc, irq_take, exc_trap, fault, brk, normal, trap_taken;
  logic [31:0] cause;
  logic [31:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
  logic        cycle_en, instret_en;

  // Strobes count only while the core runs and reset is released.
  assign halt       = (state_q == ST_BREAK) || (state_q == ST_FAULT);
  assign active     = iRST && bus.iEnable && !halt;
  assign sync_exc   = active && (bus.iInvInstr || bus.iEcall);
  assign brk        = active && !sync_exc && bus.iEbreak;
  assign irq_take   = active && !sync_exc && !bus.iEbreak && st_uie_q && ueie_q && ueip_q;
  assign exc_trap   = sync_exc && (state_q == ST_RUN);
  assign fault      = sync_exc && (state_q == ST_HANDLER);
  assign trap_taken = exc_trap || irq_take;
  assign normal     = active && !sync_exc && !bus.iEbreak && !irq_take;
  assign cause      = bus.iInvInstr ? CAUSE_ILLEGAL :
                      bus.iEcall    ? CAUSE_ECALL   : CAUSE_UEXT_IRQ;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    st_uie_d   = st_uie_q;
    st_upie_d  = st_upie_q;
    ueie_d     = ueie_q;
    ueip_d     = bus.iExtIrq;
    utvec_d    = utvec_q;
    uscratch_d = uscratch_q;
    uepc_d     = uepc_q;
    ucause_d   = ucause_q;
    utval_d    = utval_q;

    if (normal && bus.iCSRWrite) begin
      unique case (bus.iCSRAddr)
        CSR_USTATUS: begin
          st_uie_d  = bus.iCSRWData[USTATUS_UIE];
          st_upie_d = bus.iCSRWData[USTATUS_UPIE];
        end
        CSR_UIE:      ueie_d     = bus.iCSRWData[UIE_UEIE];
        CSR_UTVEC:    utvec_d    = bus.iCSRWData;
        CSR_USCRATCH: uscratch_d = bus.iCSRWData;
        CSR_UEPC:     uepc_d     = {bus.iCSRWData[31:2], 2'b00};
        CSR_UCAUSE:   ucause_d   = bus.iCSRWData;
        CSR_UTVAL:    utval_d    = bus.iCSRWData;
        default: ;
      endcase
    end

    // Applied after the CSR write so uret owns ustatus when both hit it.
    if (normal && bus.iUret) begin
      st_uie_d  = st_upie_q;
      st_upie_d = 1'b1;
      if (state_q == ST_HANDLER) state_d = ST_RUN;
    end

    if (trap_taken) begin
      uepc_d    = {bus.iPC[31:2], 2'b00};
      ucause_d  = cause;
      utval_d   = bus.iInvInstr ? bus.iInstr : 32'd0;
      st_upie_d = st_uie_q;
      st_uie_d  = 1'b0;
      state_d   = ST_HANDLER;
    end

    if (fault) state_d = ST_FAULT;

    if (brk) begin
      ret_d   = state_q;
      state_d = ST_BREAK;
    end

    if ((state_q == ST_BREAK) && bus.iResume) state_d = ret_q;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q    <= ST_RUN;
      ret_q      <= ST_RUN;
      st_uie_q   <= 1'b0;
      st_upie_q  <= 1'b0;
      ueie_q     <= 1'b0;
      ueip_q     <= 1'b0;
      utvec_q    <= TVEC_RESET;
      uscratch_q <= '0;
      uepc_q     <= '0;
      ucause_q   <= '0;
      utval_q    <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      st_uie_q   <= st_uie_d;
      st_upie_q  <= st_upie_d;
      ueie_q     <= ueie_d;
      ueip_q     <= ueip_d;
      utvec_q    <= utvec_d;
      uscratch_q <= uscratch_d;
      uepc_q     <= uepc_d;
      ucause_q   <= ucause_d;
      utval_q    <= utval_d;
    end
  end

  assign cycle_en   = !halt;
  assign instret_en = bus.iEnable && !trap_taken && !halt;

  if (HAS_COUNTERS) begin : g_cnt
    csr_counter64 u_cycle (
      .clk_i (iCLK), .clr_ni (iRST), .en_i (cycle_en),
      .lo_o  (cycle_lo), .hi_o (cycle_hi)
    );
    csr_counter64 u_instret (
      .clk_i (iCLK), .clr_ni (iRST), .en_i (instret_en),
      .lo_o  (instret_lo), .hi_o (instret_hi)
    );
  end else begin : g_nocnt
    assign cycle_lo   = '0;
    assign cycle_hi   = '0;
    assign instret_lo = '0;
    assign instret_hi = '0;
  end

  always_comb begin
    bus.oCSRRData = '0;
    unique case (bus.iCSRAddr)
      CSR_USTATUS: begin
        bus.oCSRRData[USTATUS_UIE]  = st_uie_q;
        bus.oCSRRData[USTATUS_UPIE] = st_upie_q;
      end
      CSR_UIE:      bus.oCSRRData[UIE_UEIE] = ueie_q;
      CSR_UTVEC:    bus.oCSRRData = utvec_q;
      CSR_USCRATCH: bus.oCSRRData = uscratch_q;
      CSR_UEPC:     bus.oCSRRData = uepc_q;
      CSR_UCAUSE:   bus.oCSRRData = ucause_q;
      CSR_UTVAL:    bus.oCSRRData = utval_q;
      CSR_UIP:      bus.oCSRRData[UIP_UEIP] = ueip_q;
      CSR_CYCLE:    bus.oCSRRData = cycle_lo;
      CSR_INSTRET:  bus.oCSRRData = instret_lo;
      CSR_CYCLEH:   bus.oCSRRData = cycle_hi;
      CSR_INSTRETH: bus.oCSRRData = instret_hi;
      default: ;
    endcase
  end

  assign bus.oTrapTaken = trap_taken;
  assign bus.oTrapPC    = {utvec_q[31:2], 2'b00};
  assign bus.oEPC       = uepc_q;
  assign bus.oHalt      = halt;

endmodule
